ecc_scalar_mult_ctrl: RTL and testbench

Sequencer for elliptic-curve scalar multiplication R = k·P over a WIDTH-bit scalar. It runs left-to-right double-and-add by issuing one point operation at a time (double Q, or add Q+P) to an external point-operation engine. That engine is the point-double/point-add datapath, which already contains the modular-product and inversion units. The controller resolves the point-at-infinity cases itself, so the engine never sees an infinity operand. A watchdog aborts the run if the engine stops responding.

---
 rtl/ecc_pkg.sv | 33 +++
 rtl/ecc_op_watchdog.sv | 33 +++
 rtl/ecc_scalar_mult_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ecc_scalar_mult_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ecc_pkg                                                   |
// | Brief  : Shared types and constants for the ECC scalar sequencer. |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
package ecc_pkg;

    parameter int MAX_WIDTH = 1024;

    // Wider than any supported WIDTH; users take the low WIDTH bits.
    localparam logic [MAX_WIDTH-1:0] INF_X = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STEP     = 3'd1,
        DBL_WAIT = 3'd2,
        ADD_WAIT = 3'd3,
        DONE     = 3'd4
    } state_e;

    localparam logic OP_DBL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // True when the low w bits of x are all ones.
    function automatic logic is_inf(input logic [MAX_WIDTH-1:0] x, input int unsigned w);
        logic [MAX_WIDTH-1:0] mask;
        mask = ~({MAX_WIDTH{1'b1}} << w);
        return (x & mask) == mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_op_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ecc_op_watchdog                                           |
// | Brief  : Per-operation cycle counter with saturating expire flag.  |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module ecc_op_watchdog #(
    parameter int TIMEOUT = 65536
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ecc_scalar_mult_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ecc_scalar_mult_ctrl                                      |
// | Brief  : Left-to-right double-and-add sequencer for R = k*P.       |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module ecc_scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 65536
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_px,
    input  logic [WIDTH-1:0] i_py,
    output logic             o_busy,
    output logic             o_finished,
    output logic             o_error,
    output logic [WIDTH-1:0] o_rx,
    output logic [WIDTH-1:0] o_ry,
    output logic             o_op_start,
    output logic             o_op_add,
    output logic [WIDTH-1:0] o_op_qx,
    output logic [WIDTH-1:0] o_op_qy,
    output logic [WIDTH-1:0] o_op_px,
    output logic [WIDTH-1:0] o_op_py,
    input  logic             i_op_done,
    input  logic [WIDTH-1:0] i_op_rx,
    input  logic [WIDTH-1:0] i_op_ry
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_inf_x   = INF_X[WIDTH-1:0];
    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_k, r_px, r_py, r_qx, r_qy, r_rx, r_ry;
    logic [IDX_W-1:0] r_idx;
    logic             r_busy, r_finished, r_error, r_op_start, r_op_add;

    logic             w_bit, w_q_inf, w_res_inf, w_waiting;
    logic             w_issue_dbl, w_issue_add, w_adv, w_expire;
    logic [WIDTH-1:0] w_qx_n, w_qy_n;

    assign w_bit       = r_k[r_idx];
    assign w_q_inf     = is_inf(MAX_WIDTH'(r_qx), WIDTH);
    assign w_res_inf   = is_inf(MAX_WIDTH'(i_op_rx), WIDTH);
    assign w_waiting   = (r_state == DBL_WAIT) || (r_state == ADD_WAIT);
    assign w_issue_dbl = (r_state == STEP) && !w_q_inf;

    // Next Q and whether this cycle finishes the current scalar bit.
    always_comb begin
        w_qx_n      = r_qx;
        w_qy_n      = r_qy;
        w_adv       = 1'b0;
        w_issue_add = 1'b0;
        case (r_state)
            STEP: begin
                if (w_q_inf) begin
                    w_adv = 1'b1;
                    if (w_bit) begin
                        w_qx_n = r_px;
                        w_qy_n = r_py;
                    end
                end
            end
            DBL_WAIT: begin
                if (i_op_done) begin
                    if (w_res_inf) begin
                        // 2Q = INF, so adding P collapses to Q = P without the engine.
                        w_qx_n = w_bit ? r_px : c_inf_x;
                        w_qy_n = w_bit ? r_py : '0;
                        w_adv  = 1'b1;
                    end else begin
                        w_qx_n      = i_op_rx;
                        w_qy_n      = i_op_ry;
                        w_issue_add = w_bit;
                        w_adv       = !w_bit;
                    end
                end
            end
            ADD_WAIT: begin
                if (i_op_done) begin
                    w_qx_n = i_op_rx;
                    w_qy_n = w_res_inf ? '0 : i_op_ry;
                    w_adv  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_qx       <= '0;
            r_qy       <= '0;
            r_idx      <= '0;
            r_rx       <= c_inf_x;
            r_ry       <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_error    <= 1'b0;
            r_op_start <= 1'b0;
            r_op_add   <= OP_DBL;
        end else begin
            r_op_start <= 1'b0;
            r_finished <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_k     <= i_k;
                        r_px    <= i_px;
                        r_py    <= i_py;
                        r_qx    <= c_inf_x;
                        r_qy    <= '0;
                        r_idx   <= c_idx_top;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= STEP;
                    end
                end
                STEP: begin
                    if (w_issue_dbl) begin
                        r_op_start <= 1'b1;
                        r_op_add   <= OP_DBL;
                        r_state    <= DBL_WAIT;
                    end
                end
                DBL_WAIT, ADD_WAIT: begin
                    if (w_issue_add) begin
                        r_op_start <= 1'b1;
                        r_op_add   <= OP_ADD;
                        r_state    <= ADD_WAIT;
                    end else if (!i_op_done && w_expire) begin
                        r_error    <= 1'b1;
                        r_rx       <= c_inf_x;
                        r_ry       <= '0;
                        r_finished <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if ((r_state == STEP) || w_waiting) begin
                r_qx <= w_qx_n;
                r_qy <= w_qy_n;
            end

            if (w_adv) begin
                if (r_idx == '0) begin
                    r_rx       <= w_qx_n;
                    r_ry       <= w_qy_n;
                    r_finished <= 1'b1;
                    r_state    <= DONE;
                end else begin
                    r_idx   <= r_idx - 1'b1;
                    r_state <= STEP;
                end
            end
        end
    end

    ecc_op_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_issue_dbl || w_issue_add || !w_waiting),
        .i_enable (w_waiting),
        .o_expire (w_expire)
    );

    assign o_busy     = r_busy;
    assign o_finished = r_finished;
    assign o_error    = r_error;
    assign o_rx       = r_rx;
    assign o_ry       = r_ry;
    assign o_op_start = r_op_start;
    assign o_op_add   = r_op_add;
    assign o_op_qx    = r_qx;
    assign o_op_qy    = r_qy;
    assign o_op_px    = r_px;
    assign o_op_py    = r_py;

endmodule
`default_nettype wire

// File: tb/tb_ecc_scalar_mult_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_ecc_scalar_mult_ctrl                                   |
// | Brief  : Directed bench with a token-returning engine model.       |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ecc_scalar_mult_ctrl;

    localparam int W   = 8;
    localparam int TO  = 16;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] k = '0, px = '0, py = '0;
    logic         busy, finished, error, op_start, op_add;
    logic [W-1:0] rx, ry, op_qx, op_qy, op_px, op_py;
    logic         eng_done = 1'b0, stray_done = 1'b0, eng_on = 1'b1;
    logic [W-1:0] eng_rx = '0, eng_ry = '0;
    logic         op_done;

    int errors = 0;
    int checks = 0;

    int           op_cnt = 0, cnt = 0, cyc = 0, last_done = 0;
    logic         add_log [0:63];
    logic [W-1:0] qx_log [0:63], qy_log [0:63], px_log [0:63];
    int           gap_log [0:63];

    assign op_done = eng_done | stray_done;

    always #5 clk = ~clk;

    ecc_scalar_mult_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_k(k), .i_px(px), .i_py(py),
        .o_busy(busy), .o_finished(finished), .o_error(error), .o_rx(rx), .o_ry(ry),
        .o_op_start(op_start), .o_op_add(op_add), .o_op_qx(op_qx), .o_op_qy(op_qy),
        .o_op_px(op_px), .o_op_py(op_py), .i_op_done(op_done), .i_op_rx(eng_rx), .i_op_ry(eng_ry)
    );

    // Engine model: result tokens x = 16+n, y = 64+n for the n-th operation.
    always @(negedge clk) begin
        cyc = cyc + 1;
        eng_done = 1'b0;
        if (op_start && eng_on) begin
            add_log[op_cnt] = op_add;
            qx_log[op_cnt]  = op_qx;
            qy_log[op_cnt]  = op_qy;
            px_log[op_cnt]  = op_px;
            gap_log[op_cnt] = cyc - last_done;
            op_cnt = op_cnt + 1;
            cnt = LAT;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                eng_done  = 1'b1;
                eng_rx    = W'(16 + op_cnt - 1);
                eng_ry    = W'(64 + op_cnt - 1);
                last_done = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [W-1:0] kv, input bit disturb, output int t);
        @(negedge clk);
        k = kv; px = 8'd5; py = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1;
        chk("busy_after_accept", busy, 1);
        if (disturb) begin
            stray_done = 1'b1;
            @(negedge clk); t++;
            stray_done = 1'b0;
            start = 1'b1;
            @(negedge clk); t++;
            start = 1'b0;
        end
        while (!finished && t < 300) begin
            @(negedge clk); t++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fin"}, finished, 0);
        chk({tag, "_err"}, error, 0);
        chk({tag, "_rx"}, rx, 8'hFF);
        chk({tag, "_ry"}, ry, 0);
        chk({tag, "_opst"}, op_start, 0);
        chk({tag, "_opadd"}, op_add, 0);
        chk({tag, "_opq"}, {op_qx, op_qy, op_px, op_py}, 0);
    endtask

    initial begin
        int t, t_gold, base, n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // k = 0: pure skipping, infinity result
        base = op_cnt;
        run(8'd0, 1'b0, t);
        chk("k0_latency", t, W + 1);
        chk("k0_rx", rx, 8'hFF);
        chk("k0_ry", ry, 0);
        chk("k0_err", error, 0);
        chk("k0_ops", op_cnt - base, 0);

        // k = 1: result is P, no engine use
        base = op_cnt;
        run(8'd1, 1'b0, t);
        chk("k1_latency", t, W + 1);
        chk("k1_r", {rx, ry}, {8'd5, 8'd7});
        chk("k1_ops", op_cnt - base, 0);

        // k = 5: DBL(P), DBL(tok0), ADD(tok1, P)
        base = op_cnt;
        run(8'd5, 1'b0, t_gold);
        chk("k5_ops", op_cnt - base, 3);
        chk("k5_seq", {add_log[base], add_log[base+1], add_log[base+2]}, 3'b001);
        chk("k5_q0", {qx_log[base], qy_log[base]}, {8'd5, 8'd7});
        chk("k5_q1", {qx_log[base+1], qy_log[base+1]}, {8'(16 + base), 8'(64 + base)});
        chk("k5_q2", {qx_log[base+2], qy_log[base+2]}, {8'(17 + base), 8'(65 + base)});
        chk("k5_p2", px_log[base+2], 8'd5);
        chk("k5_add_gap", gap_log[base+2], 1);
        chk("k5_r", {rx, ry}, {8'(18 + base), 8'(66 + base)});
        chk("k5_err", error, 0);

        // Engine silent: watchdog abort 16 cycles after the op start
        eng_on = 1'b0;
        @(negedge clk);
        k = 8'd5; px = 8'd5; py = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!op_start && n < 50) begin @(negedge clk); n++; end
        chk("to_op_seen", op_start, 1);
        n = 0;
        while (!finished && n < 100) begin @(negedge clk); n++; end
        chk("to_latency", n, TO);
        chk("to_err", {finished, error}, 2'b11);
        chk("to_r", {rx, ry}, {8'hFF, 8'd0});
        repeat (2) @(negedge clk);
        chk("to_err_held", error, 1);
        eng_on = 1'b1;
        base = op_cnt;
        run(8'd5, 1'b0, t);
        chk("after_to_err", error, 0);
        chk("after_to_r", {rx, ry}, {8'(18 + base), 8'(66 + base)});

        // Stray start and done during STEP must not perturb the run
        base = op_cnt;
        run(8'd5, 1'b1, t);
        chk("stray_latency", t, t_gold);
        chk("stray_ops", op_cnt - base, 3);
        chk("stray_r", {rx, ry}, {8'(18 + base), 8'(66 + base)});

        // Reset while waiting for an add
        @(negedge clk);
        k = 8'd5; px = 8'd5; py = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(op_start && op_add) && n < 100) begin @(negedge clk); n++; end
        chk("rst_add_seen", op_start & op_add, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("midrst");
        repeat (6) @(negedge clk);
        chk("midrst_idle", {busy, finished}, 2'b00);

        base = op_cnt;
        run(8'd3, 1'b0, t);
        chk("k3_ops", op_cnt - base, 2);
        chk("k3_seq", {add_log[base], add_log[base+1]}, 2'b01);
        chk("k3_r", {rx, ry}, {8'(17 + base), 8'(65 + base)});
        chk("k3_err", error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
